imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a byte stream over valid/ready. The first byte is a header holding
// the word count minus one. The data bytes follow, least-significant byte
// first. Each completed word is written at an incrementing address starting
// at 0, and the pipeline is held in reset until the whole image has arrived.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte. A mismatch on that byte puts the loader in a sticky error state.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ERROR = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd3;

  logic [2:0]    state;
  logic [AW-1:0] last_word;
  logic [AW:0]   word_idx;
  logic [BW-1:0] byte_idx;
  logic [N-1:0]  word_buf;
  logic [N-1:0]  assembled;
  logic          accept;
  logic          last_byte;
  logic          last_word_hit;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign accept        = byte_valid && byte_ready;
  assign last_byte     = (byte_idx == BW'(NB - 1));
  assign last_word_hit = (word_idx == {1'b0, last_word});

  // Merge the incoming byte into the partially assembled word at its lane
  always_comb begin
    assembled = word_buf;
    assembled[8*byte_idx +: 8] = byte_data;
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Loader state machine and the registered memory-write and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_word  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      byte_ready <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            last_word <= byte_data[AW-1:0];
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (last_byte) begin
              wr_en    <= 1'b1;
              wr_addr  <= word_idx[AW-1:0];
              wr_data  <= assembled;
              byte_idx <= '0;
              word_buf <= '0;
              if (last_word_hit) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state      <= S_CHECK;
`else
                state      <= S_DONE;
                done       <= 1'b1;
                cpu_hold   <= 1'b0;
                byte_ready <= 1'b0;
`endif
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end else begin
              word_buf <= assembled;
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks of imem_loader.
// Each load is described as a header byte plus data bytes. The reference model
// assembles those bytes into little-endian words at addresses 0..C-1. A monitor
// records every write strobe and compares it against that model. Checksum
// scenarios are built when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          done;
  logic          err;
  logic          cpu_hold;

  int vectors = 0;
  int miscompares = 0;

  logic [AW+N-1:0] got_q[$];
  logic [AW+N-1:0] exp_q[$];

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " byte_ready"}, 64'(byte_ready), 64'd1);
    check({tag, " wr_en"},      64'(wr_en),      64'd0);
    check({tag, " wr_addr"},    64'(wr_addr),    64'd0);
    check({tag, " wr_data"},    64'(wr_data),    64'd0);
    check({tag, " done"},       64'(done),       64'd0);
    check({tag, " err"},        64'(err),        64'd0);
    check({tag, " cpu_hold"},   64'(cpu_hold),   64'd1);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    reset = 1'b1;
    #2;
    check_reset_values(tag);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
  endtask

  // Model: word w is data bytes 4w..4w+3, least-significant first, written at address w
  task automatic model_words(input int count, input logic [7:0] data[$]);
    logic [N-1:0] word;
    for (int w = 0; w < count; w++) begin
      word = '0;
      for (int b = 0; b < N/8; b++) word[8*b +: 8] = data[(N/8)*w + b];
      exp_q.push_back({AW'(w), word});
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s write %0d addr", tag, i), 64'(got_q[i][AW+N-1:N]), 64'(exp_q[i][AW+N-1:N]));
      check($sformatf("%s write %0d data", tag, i), 64'(got_q[i][N-1:0]), 64'(exp_q[i][N-1:0]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Send a complete, well-formed load and check completion and every write
  task automatic run_load(input logic [7:0] hdr, input logic [7:0] data[$], input bit gaps, input string tag);
    int count;
    logic [7:0] stream[$];
    logic [7:0] x;
    count = (int'(hdr) % 64) + 1;
    model_words(count, data);
    x = 8'h00;
    stream.push_back(hdr);
    for (int i = 0; i < count * (N/8); i++) begin
      stream.push_back(data[i]);
      x = x ^ data[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(x);
`endif
    for (int i = 0; i < stream.size() - 1; i++) send_byte(stream[i], gaps);
    check({tag, " done before last byte"}, 64'(done), 64'd0);
    send_byte(stream[stream.size() - 1], gaps);
    check({tag, " done"},       64'(done),       64'd1);
    check({tag, " cpu_hold"},   64'(cpu_hold),   64'd0);
    check({tag, " byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, " err"},        64'(err),        64'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, " final wr_en with done"}, 64'(wr_en), 64'd1);
    check({tag, " final wr_addr"}, 64'(wr_addr), 64'(count - 1));
`endif
    @(posedge clk); #1;
    check({tag, " wr_en after final"}, 64'(wr_en), 64'd0);
    check_writes(tag);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [N-1:0] snap_data;
    logic [AW-1:0] snap_addr;
    logic [7:0] hdr;

    // Reset state
    apply_reset("reset");

    // Single word, no gaps, then hold after done
    d = '{8'h01, 8'h00, 8'h00, 8'hF8};
    run_load(8'h00, d, 1'b0, "single");
    snap_data = wr_data;
    snap_addr = wr_addr;
    check("single held wr_data", 64'(snap_data), 64'hF8000001);
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'($urandom);
      @(posedge clk); #1;
      check($sformatf("post-done %0d wr_en", i), 64'(wr_en), 64'd0);
      check($sformatf("post-done %0d done", i), 64'(done), 64'd1);
      check($sformatf("post-done %0d state", i),
            64'({byte_ready, cpu_hold, err, wr_addr, wr_data}),
            64'({1'b0, 1'b0, 1'b0, snap_addr, snap_data}));
    end
    byte_valid = 1'b0;
    check_writes("post-done");

    // Two words with random valid gaps
    apply_reset("reset2");
    d = '{8'h01, 8'h00, 8'h00, 8'hF8, 8'h02, 8'h80, 8'h00, 8'hF8};
    run_load(8'h01, d, 1'b1, "two-word");

    // Full 64-word image with random data
    apply_reset("reset3");
    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
    run_load(8'h3F, d, 1'b0, "full");

    // Reset in the middle of word 1 of a 2-word load
    apply_reset("reset4");
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_words(1, d);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(d[i], 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    apply_reset("mid-load reset");
    check_writes("mid-load");
    d = '{8'h03, 8'h00, 8'h83, 8'h8B};
    run_load(8'h00, d, 1'b0, "after reset");

    // Random headers (upper bits ignored) with random data and gaps
    for (int t = 0; t < 3; t++) begin
      apply_reset($sformatf("rand%0d reset", t));
      hdr = 8'($urandom_range(0, 255));
      d.delete();
      for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
      run_load(hdr, d, 1'b1, $sformatf("rand%0d", t));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Mismatching checksum ends in the error state
    apply_reset("reset5");
    d = '{8'h01, 8'h00, 8'h00, 8'hF8};
    model_words(1, d);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(d[i], 1'b0);
    send_byte(8'h00, 1'b0);
    check("bad csum err",        64'(err),        64'd1);
    check("bad csum done",       64'(done),       64'd0);
    check("bad csum cpu_hold",   64'(cpu_hold),   64'd1);
    check("bad csum byte_ready", 64'(byte_ready), 64'd0);
    check_writes("bad csum");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
